i2c_regfile_slave: RTL and testbench

I2C_REGFILE_SLAVE -- requirements
Module: i2c_regfile_slave

---
 rtl/i2c_regfile_slave.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_regfile_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_slave.sv
// Single-clock, one-bit-per-cycle I2C-style slave in front of a byte register file.
// Each bus bit occupies one clk cycle; the slave only ever pulls sda low from a registered enable.
module i2c_regfile_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         REG_DEPTH  = 16,
    parameter int         IDLE_GAP   = 10,
    localparam int        AW         = $clog2(REG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    inout  wire           sda,
    input  logic [AW-1:0] host_raddr,
    output logic [7:0]    host_rdata,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam int GW = $clog2(IDLE_GAP + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, MORE, RDATA, ACK_M, IGNORE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [6:0]    shift, shift_n;
    logic          rw, rw_n;
    logic          ack_ok, ack_ok_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          sda_oe, sda_oe_n;
    logic          we;
    logic [7:0]    regs [REG_DEPTH];
    logic [7:0]    byte_in;
    logic [7:0]    cur_byte;
    logic [7:0]    nxt_byte;
    logic [AW-1:0] ptr_inc;

    assign byte_in    = {shift, sda};
    assign ptr_inc    = ptr + AW'(1);
    assign cur_byte   = regs[ptr];
    assign nxt_byte   = regs[ptr_inc];
    assign host_rdata = regs[host_raddr];
    assign busy       = (state != IDLE);
    assign sda        = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            rw      <= 1'b0;
            ack_ok  <= 1'b0;
            ptr     <= '0;
            gap_cnt <= '0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            rw      <= rw_n;
            ack_ok  <= ack_ok_n;
            ptr     <= ptr_n;
            gap_cnt <= gap_cnt_n;
            sda_oe  <= sda_oe_n;
        end
    end

    // The enable for the next bus cycle is decided here and registered, so sda never feeds back combinationally.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        rw_n      = rw;
        ack_ok_n  = ack_ok;
        ptr_n     = ptr;
        gap_cnt_n = gap_cnt;
        sda_oe_n  = 1'b0;
        we        = 1'b0;
        case (state)
            IDLE: begin
                if (!sda) begin
                    state_n   = ADDR;
                    bit_cnt_n = '0;
                end
            end
            ADDR: begin
                shift_n   = byte_in[6:0];
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    state_n  = ACK_A;
                    rw_n     = byte_in[0];
                    ack_ok_n = (byte_in[7:1] == SLAVE_ADDR);
                    sda_oe_n = (byte_in[7:1] == SLAVE_ADDR);
                end
            end
            ACK_A: begin
                bit_cnt_n = '0;
                if (ack_ok) begin
                    state_n = REG;
                end else begin
                    state_n   = IGNORE;
                    gap_cnt_n = '0;
                end
            end
            REG: begin
                shift_n   = byte_in[6:0];
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    state_n  = ACK_R;
                    ack_ok_n = ({1'b0, byte_in} < 9'(REG_DEPTH));
                    sda_oe_n = ({1'b0, byte_in} < 9'(REG_DEPTH));
                    if ({1'b0, byte_in} < 9'(REG_DEPTH)) begin
                        ptr_n = byte_in[AW-1:0];
                    end
                end
            end
            ACK_R: begin
                bit_cnt_n = '0;
                if (!ack_ok) begin
                    state_n   = IGNORE;
                    gap_cnt_n = '0;
                end else if (rw) begin
                    state_n  = RDATA;
                    shift_n  = cur_byte[6:0];
                    sda_oe_n = ~cur_byte[7];
                end else begin
                    state_n = WDATA;
                end
            end
            WDATA: begin
                shift_n   = byte_in[6:0];
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    we       = 1'b1;
                    state_n  = ACK_W;
                    sda_oe_n = 1'b1;
                end
            end
            ACK_W: begin
                state_n = MORE;
            end
            MORE: begin
                if (sda) begin
                    state_n = IDLE;
                end else begin
                    ptr_n     = ptr_inc;
                    state_n   = WDATA;
                    bit_cnt_n = '0;
                end
            end
            RDATA: begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    state_n = ACK_M;
                end else begin
                    shift_n  = {shift[5:0], 1'b0};
                    sda_oe_n = ~shift[6];
                end
            end
            ACK_M: begin
                if (sda) begin
                    state_n = IDLE;
                end else begin
                    ptr_n     = ptr_inc;
                    state_n   = RDATA;
                    bit_cnt_n = '0;
                    shift_n   = nxt_byte[6:0];
                    sda_oe_n  = ~nxt_byte[7];
                end
            end
            IGNORE: begin
                if (sda) begin
                    if (gap_cnt == GW'(IDLE_GAP - 1)) begin
                        state_n   = IDLE;
                        gap_cnt_n = '0;
                    end else begin
                        gap_cnt_n = gap_cnt + GW'(1);
                    end
                end else begin
                    gap_cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= we;
            if (we) begin
                regs[ptr] <= byte_in;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_i2c_regfile_slave.sv
// Bench for i2c_regfile_slave: bus master tasks plus a byte-array model; monitors pop expected
// writes and read bytes from queues and compare them against what the slave presents.
module tb_i2c_regfile_slave;

    localparam logic [6:0] SLAVE_ADDR = 7'h2A;
    localparam int         REG_DEPTH  = 16;
    localparam int         IDLE_GAP   = 10;
    localparam int         AW         = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          master_low = 1'b0;
    logic [AW-1:0] host_raddr = '0;
    wire           sda;
    logic [7:0]    host_rdata;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    int            stray = 0;
    logic [7:0]    model_regs [REG_DEPTH];
    logic [7:0]    wbuf [4];
    logic [AW+7:0] exp_wr [$];
    logic [7:0]    exp_rd [$];
    logic [7:0]    obs_rd [$];
    event          rd_done;

    pullup (sda);
    assign sda = master_low ? 1'b0 : 1'bz;

    i2c_regfile_slave #(
        .SLAVE_ADDR(SLAVE_ADDR),
        .REG_DEPTH (REG_DEPTH),
        .IDLE_GAP  (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sda       (sda),
        .host_raddr(host_raddr),
        .host_rdata(host_rdata),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One bus bit: master sets its level just after the edge, the bus is observed mid-cycle.
    task automatic bus_cycle(input logic drive_low, input logic slave_slot, output logic seen);
        @(posedge clk);
        #1 master_low = drive_low;
        @(negedge clk);
        seen = sda;
        if (!drive_low && !slave_slot && seen !== 1'b1) stray++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) bus_cycle(~b[i], 1'b0, s);
    endtask

    task automatic ack_slot(output logic acked);
        logic s;
        bus_cycle(1'b0, 1'b1, s);
        acked = (s === 1'b0);
    endtask

    task automatic idle_bus(input int n);
        logic s;
        repeat (n) bus_cycle(1'b0, 1'b0, s);
    endtask

    task automatic finish_frame();
        idle_bus(IDLE_GAP + 2);
        check_output("busy_after_frame", busy, 0);
        check_output("no_stray_drive", stray, 0);
        stray = 0;
    endtask

    task automatic check_reg(input int i);
        host_raddr = AW'(i);
        #1;
        check_output("host_rdata", host_rdata, model_regs[i]);
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < REG_DEPTH; i++) check_reg(i);
    endtask

    task automatic write_frame(input logic [7:0] reg_ptr, input int n);
        logic ack;
        logic s;
        int   p;
        bus_cycle(1'b1, 1'b0, s);
        send_byte({SLAVE_ADDR, 1'b0});
        ack_slot(ack);
        check_output("wr_ack_addr", ack, 1);
        send_byte(reg_ptr);
        ack_slot(ack);
        check_output("wr_ack_reg", ack, (int'(reg_ptr) < REG_DEPTH));
        if (int'(reg_ptr) < REG_DEPTH) begin
            p = int'(reg_ptr);
            for (int i = 0; i < n; i++) begin
                exp_wr.push_back({p[AW-1:0], wbuf[i]});
                model_regs[p] = wbuf[i];
                send_byte(wbuf[i]);
                ack_slot(ack);
                check_output("wr_ack_data", ack, 1);
                bus_cycle(i != n - 1, 1'b0, s);
                p = (p + 1) % REG_DEPTH;
            end
        end else begin
            send_byte(wbuf[0] & 8'hFE);
        end
        finish_frame();
    endtask

    task automatic read_frame(input logic [7:0] reg_ptr, input int n);
        logic       ack;
        logic       s;
        logic [7:0] rb;
        int         p;
        bus_cycle(1'b1, 1'b0, s);
        send_byte({SLAVE_ADDR, 1'b1});
        ack_slot(ack);
        check_output("rd_ack_addr", ack, 1);
        send_byte(reg_ptr);
        ack_slot(ack);
        check_output("rd_ack_reg", ack, 1);
        p = int'(reg_ptr);
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(model_regs[p]);
            for (int b = 7; b >= 0; b--) begin
                bus_cycle(1'b0, 1'b1, s);
                rb[b] = s;
            end
            obs_rd.push_back(rb);
            -> rd_done;
            bus_cycle(i != n - 1, 1'b0, s);
            p = (p + 1) % REG_DEPTH;
        end
        finish_frame();
    endtask

    // A foreign address must be NACKed and the slave must sit out exactly IDLE_GAP high samples.
    task automatic bad_addr_frame(input logic [6:0] a, input logic rw);
        logic ack;
        logic s;
        bus_cycle(1'b1, 1'b0, s);
        send_byte({a, rw});
        ack_slot(ack);
        check_output("bad_addr_nack", ack, 0);
        send_byte(8'h00);
        idle_bus(IDLE_GAP);
        check_output("ignore_holds", busy, 1);
        idle_bus(1);
        check_output("ignore_rearm", busy, 0);
        finish_frame();
    endtask

    task automatic reset_midframe();
        logic ack;
        logic s;
        bus_cycle(1'b1, 1'b0, s);
        send_byte({SLAVE_ADDR, 1'b0});
        ack_slot(ack);
        check_output("rstmid_ack_addr", ack, 1);
        send_byte(8'h02);
        ack_slot(ack);
        check_output("rstmid_ack_reg", ack, 1);
        repeat (3) bus_cycle(1'b0, 1'b0, s);
        @(posedge clk);
        #1 master_low = 1'b0;
        check_output("busy_midframe", busy, 1);
        #2 rst = 1'b0;
        #1;
        check_output("rstmid_sda", sda, 1);
        check_output("rstmid_busy", busy, 0);
        check_output("rstmid_wr_valid", wr_valid, 0);
        for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        idle_bus(3);
        check_all_regs();
        finish_frame();
    endtask

    task automatic wr_monitor();
        logic [AW+7:0] e;
        forever begin
            @(negedge clk);
            if (rst && wr_valid) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL wr_unexpected: got write addr %0h data %0h, expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    check_output("wr_addr", wr_addr, e[AW+7:8]);
                    check_output("wr_data", wr_data, e[7:0]);
                end
            end
        end
    endtask

    task automatic rd_monitor();
        forever begin
            @(rd_done);
            check_output("rd_byte", obs_rd.pop_front(), exp_rd.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected test done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n;
        int         kind;
        logic [7:0] r;
        logic [6:0] a;
        for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = 8'h00;
        fork
            wr_monitor();
            rd_monitor();
        join_none

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_wr_valid", wr_valid, 0);
        check_output("rst_wr_addr", wr_addr, 0);
        check_output("rst_wr_data", wr_data, 0);
        check_output("rst_sda", sda, 1);
        check_all_regs();
        rst = 1'b1;
        idle_bus(3);

        $display("[TB] single write");
        wbuf[0] = 8'hA5;
        write_frame(8'h05, 1);
        check_reg(5);

        $display("[TB] burst write with wrap");
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_frame(8'h0F, 3);
        check_reg(15);
        check_reg(0);
        check_reg(1);

        $display("[TB] read two bytes");
        wbuf[0] = 8'hC6; wbuf[1] = 8'h3B;
        write_frame(8'h03, 2);
        read_frame(8'h03, 2);

        $display("[TB] wrong address then valid frame");
        bad_addr_frame(7'h2B, 1'b0);
        wbuf[0] = 8'h5A;
        write_frame(8'h07, 1);
        check_reg(7);

        $display("[TB] out-of-range register");
        wbuf[0] = 8'h77;
        write_frame(8'h10, 1);
        check_all_regs();

        $display("[TB] reset mid write");
        reset_midframe();
        wbuf[0] = 8'h9C;
        write_frame(8'h02, 1);
        read_frame(8'h02, 1);

        $display("[TB] random frames");
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                n = $urandom_range(1, 4);
                for (int j = 0; j < 4; j++) wbuf[j] = 8'($urandom);
                r = (kind == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
                write_frame(r, n);
            end else if (kind < 9) begin
                read_frame(8'($urandom_range(0, 15)), $urandom_range(1, 4));
            end else begin
                a = 7'($urandom_range(0, 127));
                if (a == SLAVE_ADDR) a = a ^ 7'h01;
                bad_addr_frame(a, 1'($urandom));
            end
            check_reg($urandom_range(0, REG_DEPTH - 1));
        end

        check_all_regs();
        check_output("wr_pending", exp_wr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
